// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller: sequences a dual-port storage array, tracks occupancy and status flags.
// Optional sticky overflow/underflow registers are built when FIFO_CTRL_ERR_FLAGS_EN is defined.
module fifo_ctrl #(
  parameter int unsigned ADDRESS_SIZE = 2,
  parameter int unsigned MEMORY_DEPTH = 4,
  parameter int unsigned AF_LEVEL     = 3,
  parameter int unsigned AE_LEVEL     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_req,
  input  logic                    rd_req,
  output logic                    cw_en,
  output logic                    cr_en,
  output logic [ADDRESS_SIZE-1:0] w_ptr,
  output logic [ADDRESS_SIZE-1:0] r_ptr,
  output logic [ADDRESS_SIZE:0]   count,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    rvalid,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned CW = ADDRESS_SIZE + 1;

  // Flags are decoded from registered count only.
  assign full         = (count == CW'(MEMORY_DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // A read while full frees the slot this write lands in; reads never fall through an empty FIFO.
  assign cw_en = wr_req & (~full | rd_req);
  assign cr_en = rd_req & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr  <= '0;
      r_ptr  <= '0;
      count  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= cr_en;
      if (cw_en) w_ptr <= w_ptr + ADDRESS_SIZE'(1);
      if (cr_en) r_ptr <= r_ptr + ADDRESS_SIZE'(1);
      case ({cw_en, cr_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_req & ~cw_en) overflow  <= 1'b1;
      if (rd_req & empty)  underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized bench for fifo_ctrl against a queue-based occupancy/ordering model.
module tb_fifo_ctrl;
  localparam int unsigned AS    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AF    = 3;
  localparam int unsigned AE    = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req, rd_req;
  logic          cw_en, cr_en;
  logic [AS-1:0] w_ptr, r_ptr;
  logic [AS:0]   count;
  logic          full, empty, almost_full, almost_empty;
  logic          rvalid, overflow, underflow;

  fifo_ctrl #(
    .ADDRESS_SIZE(AS), .MEMORY_DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req),
    .cw_en(cw_en), .cr_en(cr_en), .w_ptr(w_ptr), .r_ptr(r_ptr),
    .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .rvalid(rvalid), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: queue of write sequence numbers; addresses are sequence number mod depth.
  int q[$];
  int wr_total;
  int rd_total;
  bit prev_rd;
  bit ov_seen;
  bit un_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    wr_total = 0;
    rd_total = 0;
    prev_rd  = 1'b0;
    ov_seen  = 1'b0;
    un_seen  = 1'b0;
  endtask

  task automatic check_state();
    int n;
    n = q.size();
    check("count", 32'(count), 32'(n));
    check("full", 32'(full), 32'(n == int'(DEPTH)));
    check("empty", 32'(empty), 32'(n == 0));
    check("almost_full", 32'(almost_full), 32'(n >= int'(AF)));
    check("almost_empty", 32'(almost_empty), 32'(n <= int'(AE)));
    check("w_ptr", 32'(w_ptr), 32'(wr_total % int'(DEPTH)));
    check("r_ptr", 32'(r_ptr), 32'(rd_total % int'(DEPTH)));
    check("rvalid", 32'(rvalid), 32'(prev_rd));
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    check("overflow", 32'(overflow), 32'(ov_seen));
    check("underflow", 32'(underflow), 32'(un_seen));
`else
    check("overflow", 32'(overflow), 32'(0));
    check("underflow", 32'(underflow), 32'(0));
`endif
  endtask

  task automatic step(input bit wr, input bit rd);
    bit exp_cw, exp_cr;
    int n;
    @(negedge clk);
    wr_req = wr;
    rd_req = rd;
    #1;
    n = q.size();
    exp_cw = wr && (n < int'(DEPTH) || rd);
    exp_cr = rd && (n > 0);
    check_state();
    check("cw_en", 32'(cw_en), 32'(exp_cw));
    check("cr_en", 32'(cr_en), 32'(exp_cr));
    // The read address must be the address the oldest outstanding word was written to.
    if (exp_cr) check("rd_order", 32'(r_ptr), 32'(q[0] % int'(DEPTH)));
    @(posedge clk);
    if (wr && !exp_cw) ov_seen = 1'b1;
    if (rd && n == 0)  un_seen = 1'b1;
    if (exp_cr) begin
      void'(q.pop_front());
      rd_total++;
    end
    if (exp_cw) begin
      q.push_back(wr_total);
      wr_total++;
    end
    prev_rd = exp_cr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int p_wr, p_rd;
    rst    = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    model_clear();
    do_reset();

    // Idle, fill past full, full with simultaneous read/write.
    step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    // Drain, then read/write together on empty.
    repeat (4) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    // Interleaved stream across pointer wrap.
    for (int i = 0; i < 10; i++) step(1'b1, i > 0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Asynchronous reset while a read is being accepted at count 2.
    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    @(negedge clk);
    wr_req = 1'b0;
    rd_req = 1'b1;
    #1;
    check("pre_rst_cr_en", 32'(cr_en), 32'(1));
    check("pre_rst_count", 32'(count), 32'(2));
    #2;
    rst = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'(0));
    check("rst_w_ptr", 32'(w_ptr), 32'(0));
    check("rst_r_ptr", 32'(r_ptr), 32'(0));
    check("rst_rvalid", 32'(rvalid), 32'(0));
    check("rst_empty", 32'(empty), 32'(1));
    @(negedge clk);
    rst    = 1'b0;
    rd_req = 1'b0;
    model_clear();
    step(1'b0, 1'b0);

    // Random phases biased toward filling, draining and balanced traffic.
    for (int ph = 0; ph < 8; ph++) begin
      case (ph % 4)
        0:       begin p_wr = 80; p_rd = 20; end
        1:       begin p_wr = 20; p_rd = 80; end
        2:       begin p_wr = 60; p_rd = 60; end
        default: begin p_wr = 95; p_rd = 95; end
      endcase
      repeat (50) step($urandom_range(0, 99) < 32'(p_wr), $urandom_range(0, 99) < 32'(p_rd));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
